// File: rtl/adaptive_filter_tdm.sv
// Time-multiplexed multi-channel filter: bypass, differentiator, integrator or leaky integrator per channel.
// One shared saturating datapath, private per-channel history, valid/ready streaming with one-cycle latency.
module adaptive_filter_tdm #(
    parameter int WORDLENGTH        = 14,
    parameter int FRACTIONAL_LENGTH = 6,
    parameter int CHANNELS          = 4,
    parameter int LEAK_SHIFT        = 4,
    localparam int IDW              = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [WORDLENGTH-1:0] s_tdata,
    input  logic [IDW-1:0]        s_tid,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [WORDLENGTH-1:0] m_tdata,
    output logic [IDW-1:0]        m_tid,
    output logic                  m_tsat
);

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_DIFF   = 2'b01,
        MODE_INTEG  = 2'b10,
        MODE_LEAKY  = 2'b11
    } mode_t;

    localparam int AW = WORDLENGTH + 2;
    localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (WORDLENGTH - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    if (CHANNELS < 1 || CHANNELS > 16 || LEAK_SHIFT < 1 || LEAK_SHIFT >= WORDLENGTH ||
        FRACTIONAL_LENGTH < 0 || FRACTIONAL_LENGTH >= WORDLENGTH) begin : g_param_check
        $error("adaptive_filter_tdm: illegal parameter combination");
    end

    logic signed [WORDLENGTH-1:0] r_x_prev    [CHANNELS];
    logic signed [WORDLENGTH-1:0] r_y_prev    [CHANNELS];
    mode_t                        r_last_mode [CHANNELS];

    logic                         w_accept;
    logic                         w_id_ok;
    logic                         w_clear;
    logic                         w_sat;
    mode_t                        w_mode;
    mode_t                        w_last_mode;
    logic signed [WORDLENGTH-1:0] w_xp;
    logic signed [WORDLENGTH-1:0] w_yp;
    logic signed [AW-1:0]         w_x;
    logic signed [AW-1:0]         w_hx;
    logic signed [AW-1:0]         w_hy;
    logic signed [AW-1:0]         w_y;
    logic signed [WORDLENGTH-1:0] w_y_sat;

    assign s_tready = !m_tvalid || m_tready;
    assign w_accept = s_tvalid && s_tready;

    always_comb begin
        w_id_ok     = 1'b0;
        w_mode      = MODE_BYPASS;
        w_last_mode = MODE_BYPASS;
        w_xp        = '0;
        w_yp        = '0;
        // Mux-style channel select keeps out-of-range IDs from indexing past the history arrays.
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (s_tid == IDW'(c)) begin
                w_id_ok     = 1'b1;
                w_mode      = mode_t'(mode[2*c +: 2]);
                w_last_mode = r_last_mode[c];
                w_xp        = r_x_prev[c];
                w_yp        = r_y_prev[c];
            end
        end

        w_clear = (w_mode != w_last_mode);
        w_x     = AW'($signed(s_tdata));
        w_hx    = w_clear ? '0 : AW'(w_xp);
        w_hy    = w_clear ? '0 : AW'(w_yp);

        case (w_mode)
            MODE_BYPASS: w_y = w_x;
            MODE_DIFF:   w_y = w_x - w_hx;
            MODE_INTEG:  w_y = w_hy + w_x;
            default:     w_y = w_hy - (w_hy >>> LEAK_SHIFT) + w_x;
        endcase

        w_sat   = 1'b0;
        w_y_sat = w_y[WORDLENGTH-1:0];
        if (w_y > SAT_MAX) begin
            w_sat   = 1'b1;
            w_y_sat = SAT_MAX[WORDLENGTH-1:0];
        end else if (w_y < SAT_MIN) begin
            w_sat   = 1'b1;
            w_y_sat = SAT_MIN[WORDLENGTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tid    <= '0;
            m_tsat   <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                r_x_prev[c]    <= '0;
                r_y_prev[c]    <= '0;
                r_last_mode[c] <= MODE_BYPASS;
            end
        end else if (w_accept) begin
            m_tvalid <= w_id_ok;
            if (w_id_ok) begin
                m_tdata <= w_y_sat;
                m_tid   <= s_tid;
                m_tsat  <= w_sat;
            end
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (s_tid == IDW'(c)) begin
                    r_x_prev[c]    <= $signed(s_tdata);
                    r_y_prev[c]    <= w_y_sat;
                    r_last_mode[c] <= w_mode;
                end
            end
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adaptive_filter_tdm.sv
// Scoreboard bench for adaptive_filter_tdm: directed vectors push expected outputs,
// a negedge monitor pops and compares on every output transfer.
module tb_adaptive_filter_tdm;

    localparam int W   = 14;
    localparam int CH  = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            srst;
    logic [2*CH-1:0] mode;
    logic            s_tvalid;
    logic            s_tready;
    logic [W-1:0]    s_tdata;
    logic [IDW-1:0]  s_tid;
    logic            m_tvalid;
    logic            m_tready;
    logic [W-1:0]    m_tdata;
    logic [IDW-1:0]  m_tid;
    logic            m_tsat;

    logic rnd_en    = 1'b0;
    logic rdy_force = 1'b1;
    logic rnd_bit   = 1'b1;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
        logic           sat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    assign m_tready = rnd_en ? rnd_bit : rdy_force;

    adaptive_filter_tdm #(
        .WORDLENGTH        (W),
        .FRACTIONAL_LENGTH (6),
        .CHANNELS          (CH),
        .LEAK_SHIFT        (4)
    ) dut (
        .clk      (clk),
        .srst     (srst),
        .mode     (mode),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tid    (s_tid),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tid    (m_tid),
        .m_tsat   (m_tsat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!srst && m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got tid=%0d data=%0h, required no output", m_tid, m_tdata);
                end else begin
                    e = sb.pop_front();
                    check("out_tid", 32'(m_tid), 32'(e.id));
                    check("out_data", 32'(m_tdata), 32'(e.data));
                    check("out_sat", 32'(m_tsat), 32'(e.sat));
                end
            end
        end
    end

    task automatic setm(input int ch, input logic [1:0] m);
        mode[2*ch +: 2] = m;
    endtask

    task automatic send(input int id, input int x, input int ey, input logic esat, input logic expect_out);
        logic acc;
        exp_t e;
        acc      = 1'b0;
        s_tid    = id[IDW-1:0];
        s_tdata  = x[W-1:0];
        s_tvalid = 1'b1;
        for (int n = 0; n < 1000 && !acc; n++) begin
            @(negedge clk);
            if (s_tready) begin
                acc = 1'b1;
                if (expect_out) begin
                    e.id   = id[IDW-1:0];
                    e.data = ey[W-1:0];
                    e.sat  = esat;
                    sb.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no acceptance, required acceptance of ch%0d", id);
        end else begin
            check("lat_valid", 32'(m_tvalid), 32'd1);
            check("lat_tid", 32'(m_tid), 32'(id));
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && sb.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        srst     = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst     = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tid    = '0;
        mode     = '0;
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
        check("rst_valid", 32'(m_tvalid), 32'd0);
        check("rst_data", 32'(m_tdata), 32'd0);
        check("rst_tid", 32'(m_tid), 32'd0);
        check("rst_sat", 32'(m_tsat), 32'd0);
        check("rst_sready", 32'(s_tready), 32'd1);

        // Integrator
        setm(0, 2'b10);
        for (int k = 1; k <= 5; k++) send(0, 64, 64 * k, 1'b0, 1'b1);
        drain();

        // Differentiator and leaky integrator
        do_reset();
        setm(1, 2'b01);
        send(1, 0, 0, 1'b0, 1'b1);
        send(1, 64, 64, 1'b0, 1'b1);
        send(1, 128, 64, 1'b0, 1'b1);
        send(1, 128, 0, 1'b0, 1'b1);
        setm(3, 2'b11);
        send(3, 256, 256, 1'b0, 1'b1);
        send(3, 256, 496, 1'b0, 1'b1);
        drain();

        // Positive saturation without wind-up
        do_reset();
        setm(2, 2'b10);
        send(2, 4096, 4096, 1'b0, 1'b1);
        send(2, 4096, 8191, 1'b1, 1'b1);
        send(2, -64, 8127, 1'b0, 1'b1);
        drain();

        // Negative boundary: exact minimum is not clipped, beyond it is
        do_reset();
        setm(2, 2'b10);
        send(2, -4096, -4096, 1'b0, 1'b1);
        send(2, -4096, -8192, 1'b0, 1'b1);
        send(2, -4096, -8192, 1'b1, 1'b1);
        setm(1, 2'b00);
        send(1, -8192, -8192, 1'b0, 1'b1);
        setm(1, 2'b01);
        send(1, 8191, 8191, 1'b0, 1'b1);
        send(1, -8192, -8192, 1'b1, 1'b1);
        drain();

        // Interleaved channels back-to-back
        do_reset();
        setm(0, 2'b10);
        setm(1, 2'b01);
        send(0, 64, 64, 1'b0, 1'b1);
        send(1, 100, 100, 1'b0, 1'b1);
        send(0, 64, 128, 1'b0, 1'b1);
        send(1, 150, 50, 1'b0, 1'b1);
        drain();

        // Backpressure hold
        do_reset();
        rdy_force = 1'b0;
        setm(0, 2'b10);
        send(0, 64, 64, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(m_tvalid), 32'd1);
            check("hold_data", 32'(m_tdata), 32'd64);
            check("hold_tid", 32'(m_tid), 32'd0);
            check("hold_sat", 32'(m_tsat), 32'd0);
            check("hold_sready", 32'(s_tready), 32'd0);
        end
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        drain();

        // Random m_tready over 200 samples: ch0 integrates 1s, ch1 bypasses a ramp
        do_reset();
        setm(0, 2'b10);
        setm(1, 2'b00);
        rnd_en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (k % 2 == 0) send(0, 1, k / 2 + 1, 1'b0, 1'b1);
            else            send(1, k, k, 1'b0, 1'b1);
        end
        rnd_en    = 1'b0;
        rdy_force = 1'b1;
        drain();

        // Mode switch clears history, then reset mid-stream
        do_reset();
        setm(0, 2'b10);
        send(0, 64, 64, 1'b0, 1'b1);
        send(0, 64, 128, 1'b0, 1'b1);
        send(0, 64, 192, 1'b0, 1'b1);
        setm(0, 2'b01);
        send(0, 64, 64, 1'b0, 1'b1);
        drain();
        rdy_force = 1'b0;
        setm(1, 2'b00);
        send(1, 5, 5, 1'b0, 1'b0);
        check("pre_rst_valid", 32'(m_tvalid), 32'd1);
        do_reset();
        check("mid_rst_valid", 32'(m_tvalid), 32'd0);
        check("mid_rst_data", 32'(m_tdata), 32'd0);
        check("mid_rst_tid", 32'(m_tid), 32'd0);
        check("mid_rst_sat", 32'(m_tsat), 32'd0);
        rdy_force = 1'b1;
        setm(0, 2'b10);
        send(0, 64, 64, 1'b0, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
